// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between issue-slot operand fetch, the shared ALU and writeback.
interface alu_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_op1;
    logic [NUM_REQ*32-1:0] req_op2;
    logic [NUM_REQ-1:0]    req_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic [3:0]            rsp_flags;

    // Requester / writeback side
    modport master (
        output req_valid, req_op1, req_op2, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_op1, req_op2, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit add/sub ALU across NUM_REQ issue slots.
// Optional per-slot saturating grant counters enabled by ALU_ARB_STATS_EN.
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_share_arbiter_if.slave      bus,
    output logic [NUM_REQ*16-1:0]   stat_grants
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     ptr_d;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic [FLAG_W-1:0]   rsp_flags_q;

    logic                can_accept_c;
    logic                accept_c;
    logic [ID_W-1:0]     grant_idx_c;
    logic [NUM_REQ-1:0]  grant_c;

    logic [DATA_W-1:0]   op1_arr [NUM_REQ];
    logic [DATA_W-1:0]   op2_arr [NUM_REQ];
    logic [DATA_W-1:0]   op1_c;
    logic [DATA_W-1:0]   op2_c;
    logic [DATA_W-1:0]   b_eff_c;
    logic [DATA_W-1:0]   result_c;
    logic                sub_c;
    logic                carry_c;
    logic [FLAG_W-1:0]   flags_c;

    // Unpack per-slot operands
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op1_arr[i] = bus.req_op1[i*DATA_W +: DATA_W];
        assign op2_arr[i] = bus.req_op2[i*DATA_W +: DATA_W];
    end

    assign can_accept_c = (state_q == EMPTY) || ((state_q == FULL) && bus.rsp_ready);

    // First valid slot at or above ptr, wrapping; depends only on valid/ptr/rsp state
    always_comb begin
        int unsigned     idx;
        logic [ID_W-1:0] idx_w;
        logic            found;
        idx         = 0;
        idx_w       = '0;
        found       = 1'b0;
        grant_idx_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (!found && bus.req_valid[idx_w]) begin
                found       = 1'b1;
                grant_idx_c = idx_w;
            end
        end
        accept_c = found && can_accept_c;
        grant_c  = '0;
        if (accept_c) begin
            grant_c[grant_idx_c] = 1'b1;
        end
    end

    assign bus.req_ready = grant_c;

    // Shared add/sub datapath on the granted slot
    always_comb begin
        op1_c    = op1_arr[grant_idx_c];
        op2_c    = op2_arr[grant_idx_c];
        sub_c    = bus.req_sub[grant_idx_c];
        b_eff_c  = sub_c ? (~op2_c + 32'd1) : op2_c;
        {carry_c, result_c} = {1'b0, op1_c} + {1'b0, b_eff_c};
        flags_c  = {(result_c == '0),
                    result_c[DATA_W-1],
                    carry_c,
                    (op1_c[DATA_W-1] == b_eff_c[DATA_W-1]) && (result_c[DATA_W-1] != op1_c[DATA_W-1])};
    end

    // Output-stage state and round-robin pointer update
    always_comb begin
        int unsigned nxt;
        state_d = state_q;
        ptr_d   = ptr_q;
        nxt     = 0;
        case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept_c) begin
                    state_d = FULL;
                end else if (bus.rsp_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (accept_c) begin
            nxt = 32'(grant_idx_c) + 1;
            if (nxt >= NUM_REQ) begin
                nxt = 0;
            end
            ptr_d = ID_W'(nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            ptr_q        <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (accept_c) begin
                rsp_id_q     <= grant_idx_c;
                rsp_result_q <= result_c;
                rsp_flags_q  <= flags_c;
            end
        end
    end

    assign bus.rsp_valid  = (state_q == FULL);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    // Saturating per-slot accept counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant_c[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        assign stat_grants[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (default or ALU_ARB_STATS_EN build).
module tb_alu_share_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ*16-1:0] stat_grants;

    int total = 0;
    int bad   = 0;

    alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .stat_grants (stat_grants)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int s, input logic [31:0] a, input logic [31:0] b, input logic sub);
        bus.req_op1[s*32 +: 32] = a;
        bus.req_op2[s*32 +: 32] = b;
        bus.req_sub[s]          = sub;
    endtask

    // One isolated request: grant, 1-cycle result, then drain to empty with data held
    task automatic single(input int s, input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] er, input logic [3:0] ef);
        logic [3:0] exp_rdy;
        exp_rdy    = '0;
        exp_rdy[s] = 1'b1;
        @(negedge clk);
        bus.req_valid = '0;
        set_slot(s, a, b, sub);
        bus.req_valid[s] = 1'b1;
        bus.rsp_ready    = 1'b1;
        #1 chk("single_ready", 64'(bus.req_ready), 64'(exp_rdy));
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("single_valid", 64'(bus.rsp_valid), 64'd1);
        chk("single_id", 64'(bus.rsp_id), 64'(s));
        chk("single_result", 64'(bus.rsp_result), 64'(er));
        chk("single_flags", 64'(bus.rsp_flags), 64'(ef));
        @(negedge clk);
        #1;
        chk("drain_valid", 64'(bus.rsp_valid), 64'd0);
        chk("drain_hold", 64'(bus.rsp_result), 64'(er));
    endtask

    initial begin
        logic [3:0] exp_rdy;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.req_sub   = '0;
        bus.rsp_ready = 1'b0;
        #12;
        chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_result", 64'(bus.rsp_result), 64'd0);
        chk("rst_flags", 64'(bus.rsp_flags), 64'd0);
        chk("rst_stats", stat_grants, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        single(2, 32'd5, 32'd7, 1'b0, 32'd12, 4'b0000);
        single(0, 32'h10, 32'h10, 1'b1, 32'h0, 4'b1010);
        single(0, 32'd3, 32'd0, 1'b1, 32'd3, 4'b0000);
        single(1, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 4'b0101);
        single(2, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 4'b1010);
        single(3, 32'd1, 32'd2, 1'b1, 32'hFFFF_FFFF, 4'b0100);

        // All slots valid: ptr is 0 after slot 3, expect 0,1,2,3,0,...
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            set_slot(i, 32'(i + 1), 32'd10, 1'b0);
        end
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            exp_rdy = '0;
            exp_rdy[k % 4] = 1'b1;
            #1;
            chk("rr_ready", 64'(bus.req_ready), 64'(exp_rdy));
            if (k > 0) begin
                chk("rr_valid", 64'(bus.rsp_valid), 64'd1);
                chk("rr_id", 64'(bus.rsp_id), 64'((k - 1) % 4));
                chk("rr_result", 64'(bus.rsp_result), 64'(((k - 1) % 4) + 11));
            end
        end

        // Backpressure with slot 1 pending while slot 3 result sits in the stage
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        set_slot(1, 32'd20, 32'd5, 1'b1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("bp_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_id", 64'(bus.rsp_id), 64'd3);
            chk("bp_result", 64'(bus.rsp_result), 64'd14);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(bus.req_ready), 64'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("bp_id1", 64'(bus.rsp_id), 64'd1);
        chk("bp_result1", 64'(bus.rsp_result), 64'd15);
        chk("bp_flags1", 64'(bus.rsp_flags), 64'b0010);

`ifndef ALU_ARB_STATS_EN
        chk("stats_off", stat_grants, 64'd0);
`endif

        // Reset while a fresh result is held
        @(negedge clk);
        set_slot(0, 32'd9, 32'd9, 1'b0);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        bus.req_valid = '0;
        #1 chk("pre_rst_valid", 64'(bus.rsp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_result", 64'(bus.rsp_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("post_rst_valid", 64'(bus.rsp_valid), 64'd0);

`ifdef ALU_ARB_STATS_EN
        // Saturation of slot 3 counter
        @(negedge clk);
        set_slot(3, 32'd1, 32'd1, 1'b0);
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1 chk("stats_5", stat_grants, {16'd5, 48'd0});
        repeat (69995) @(negedge clk);
        #1 chk("stats_sat", stat_grants, {16'hFFFF, 48'd0});
        bus.req_valid = '0;
`else
        chk("stats_off_end", stat_grants, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
